sa_ram_rws_param: RTL and testbench

//  Parametrised 1R1W synchronous RAM model for systolic-array buffers; next generation of the fixed 256x128 rws model.

---
 rtl/sa_ram_rws_param.sv | 99 +++++++++
 tb/tb_sa_ram_rws_param.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sa_ram_rws_param.sv
// Parametrised 1R1W synchronous RAM for systolic-array buffers: byte-enable writes,
// optional same-address bypass, optional output register, read strobe and collision counter.
module sa_ram_rws_param #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int DW      = 128,
  parameter int BW      = 8,
  parameter int OUT_REG = 0,
  parameter int BYPASS  = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      ra,
  input  logic               re,
  output logic [DW-1:0]      dout,
  output logic               dout_vld,
  input  logic [AW-1:0]      wa,
  input  logic               we,
  input  logic [DW/BW-1:0]   wbe,
  input  logic [DW-1:0]      di,
  input  logic [31:0]        pwrbus_ram_pd,
  output logic               rw_collision,
  output logic [CNT_W-1:0]   coll_cnt
);
  localparam int NB = DW / BW;

  logic             pd, rd, wr, ra_ok, wa_ok, coll;
  logic [DW-1:0]    mem [DEPTH];
  logic [DW-1:0]    old_w, rd_w;
  logic [DW-1:0]    rdata_q;
  logic             rvld_q, coll_q;
  logic [CNT_W-1:0] cnt_q;
  logic             unused_pd_hi;

  assign pd           = pwrbus_ram_pd[0];
  assign unused_pd_hi = ^pwrbus_ram_pd[31:1];
  assign rd    = re & ~rst & ~pd;
  assign wr    = we & ~rst & ~pd;
  assign ra_ok = {1'b0, ra} < (AW+1)'(DEPTH);
  assign wa_ok = {1'b0, wa} < (AW+1)'(DEPTH);
  assign coll  = rd & wr & (ra == wa) & ra_ok;

  // Out-of-range reads return zero; on collision with BYPASS the written lanes win.
  always_comb begin
    old_w = ra_ok ? mem[ra] : '0;
    rd_w  = old_w;
    if (BYPASS != 0 && coll) begin
      for (int i = 0; i < NB; i++)
        if (wbe[i]) rd_w[i*BW +: BW] = di[i*BW +: BW];
    end
  end

  always_ff @(posedge clk) begin
    if (wr && wa_ok) begin
      for (int i = 0; i < NB; i++)
        if (wbe[i]) mem[wa][i*BW +: BW] <= di[i*BW +: BW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      coll_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      rvld_q <= rd;
      if (rd) rdata_q <= rd_w;
      coll_q <= coll;
      if (coll && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign rw_collision = coll_q;
  assign coll_cnt     = cnt_q;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DW-1:0] dout_q;
      logic          vld2_q;
      // Second stage ignores pd so reads already in flight still complete.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
          vld2_q <= 1'b0;
        end else begin
          vld2_q <= rvld_q;
          if (rvld_q) dout_q <= rdata_q;
        end
      end
      assign dout     = dout_q;
      assign dout_vld = vld2_q;
    end else begin : g_noreg
      assign dout     = rdata_q;
      assign dout_vld = rvld_q;
    end
  endgenerate
endmodule

// File: tb/tb_sa_ram_rws_param.sv
// Two DUT configurations driven in parallel; a behavioural memory model fills a scoreboard
// that a negedge monitor drains against dout/dout_vld, rw_collision and coll_cnt.
module tb_sa_ram_rws_param;
  logic         clk, rst, re, we;
  logic [7:0]   ra, wa;
  logic [15:0]  wbe;
  logic [127:0] di;
  logic [31:0]  pwr;
  logic [127:0] dout0, dout1;
  logic         vld0, vld1, rc0, rc1;
  logic [15:0]  cnt0;
  logic [1:0]   cnt1;

  sa_ram_rws_param #(.DEPTH(256), .AW(8), .DW(128), .BW(8), .OUT_REG(0), .BYPASS(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout0), .dout_vld(vld0), .wa(wa), .we(we),
    .wbe(wbe), .di(di), .pwrbus_ram_pd(pwr), .rw_collision(rc0), .coll_cnt(cnt0));

  sa_ram_rws_param #(.DEPTH(200), .AW(8), .DW(128), .BW(8), .OUT_REG(1), .BYPASS(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout1), .dout_vld(vld1), .wa(wa), .we(we),
    .wbe(wbe), .di(di), .pwrbus_ram_pd(pwr), .rw_collision(rc1), .coll_cnt(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int inst; int due; logic [127:0] d; } ent_t;
  ent_t         sq[$];
  logic [127:0] mm [2][256];
  logic [127:0] exp_dout [2];
  logic         exp_coll [2];
  int           exp_cnt  [2];
  int           ecnt = 0, nchk = 0, npass = 0;
  bit           started = 0;

  task automatic chk(input string nm, input int k, input logic [127:0] a, input logic [127:0] e);
    nchk++;
    if (a === e) npass++;
    else $display("FAIL %s[dut%0d] cyc %0d got %h exp %h", nm, k, ecnt, a, e);
  endtask

  // Reference: read returns array word (or zero past DEPTH), bypassed lanes on collision if enabled.
  task automatic step(input logic r, input logic rre, input logic wwe, input logic ppd,
                      input logic [7:0] rra, input logic [7:0] wwa, input logic [15:0] be,
                      input logic [127:0] d);
    rst = r; re = rre; we = wwe; pwr = {31'h5a5a_5a5a, ppd};
    ra = rra; wa = wwa; wbe = be; di = d;
    @(posedge clk);
    ecnt++;
    for (int k = 0; k < 2; k++) begin
      int dep, lat, mx;
      bit byp, acc, rdk, wrk, cl;
      logic [127:0] data;
      dep = k ? 200 : 256; lat = k ? 2 : 1; byp = (k == 0); mx = k ? 3 : 65535;
      acc = !r && !ppd;
      rdk = rre && acc;
      wrk = wwe && acc;
      cl  = rdk && wrk && (rra == wwa) && (int'(rra) < dep);
      if (r) begin
        for (int i = sq.size() - 1; i >= 0; i--) if (sq[i].inst == k) sq.delete(i);
        exp_dout[k] = '0; exp_coll[k] = 1'b0; exp_cnt[k] = 0;
      end else begin
        if (rdk) begin
          data = (int'(rra) < dep) ? mm[k][rra] : '0;
          if (cl && byp)
            for (int i = 0; i < 16; i++) if (be[i]) data[i*8 +: 8] = d[i*8 +: 8];
          sq.push_back('{k, ecnt + lat - 1, data});
        end
        exp_coll[k] = cl;
        if (cl && exp_cnt[k] < mx) exp_cnt[k]++;
        if (wrk && int'(wwa) < dep)
          for (int i = 0; i < 16; i++) if (be[i]) mm[k][wwa][i*8 +: 8] = d[i*8 +: 8];
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'd0, 8'd0, 16'h0, '0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] m_d;
  logic         m_v, m_c;
  int           m_n, m_idx;
  bit           m_exp;

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        m_d = k ? dout1 : dout0;
        m_v = k ? vld1 : vld0;
        m_c = k ? rc1 : rc0;
        m_n = k ? int'(cnt1) : int'(cnt0);
        m_idx = -1;
        for (int i = 0; i < sq.size(); i++)
          if (sq[i].inst == k) begin m_idx = i; break; end
        m_exp = (m_idx >= 0) && (sq[m_idx].due <= ecnt);
        chk("dout_vld", k, 128'(m_v), 128'(m_exp));
        if (m_exp) begin
          exp_dout[k] = sq[m_idx].d;
          sq.delete(m_idx);
        end
        chk("dout", k, m_d, exp_dout[k]);
        chk("rw_collision", k, 128'(m_c), 128'(exp_coll[k]));
        chk("coll_cnt", k, 128'(m_n), 128'(exp_cnt[k]));
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 8'd0, 8'd0, 16'h0, '0);
    started = 1;
    step(1, 0, 0, 0, 8'd0, 8'd0, 16'h0, '0);
    for (int a = 0; a < 256; a++) step(0, 0, 1, 0, 8'd0, 8'(a), 16'hFFFF, rnd128());
    idle(2);
    // reset blocks reads and writes, then M[5] still holds its prefill value
    step(1, 1, 1, 0, 8'd5, 8'd5, 16'hFFFF, rnd128());
    step(1, 1, 1, 0, 8'd5, 8'd5, 16'hFFFF, rnd128());
    step(0, 1, 0, 0, 8'd5, 8'd0, 16'h0, '0);
    idle(3);
    // byte-enable partial write
    step(0, 0, 1, 0, 8'd0, 8'd3, 16'hFFFF, {16{8'hAA}});
    step(0, 0, 1, 0, 8'd0, 8'd3, 16'h0001, {16{8'h55}});
    step(0, 1, 0, 0, 8'd3, 8'd0, 16'h0, '0);
    idle(3);
    // collision
    step(0, 0, 1, 0, 8'd0, 8'd7, 16'hFFFF, '0);
    step(0, 1, 1, 0, 8'd7, 8'd7, 16'hFFFF, 128'h1234);
    idle(3);
    // back-to-back reads
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 8'(i), 8'd0, 16'h0, '0);
    idle(3);
    // power-down hold, with a read in flight when pd rises
    step(0, 0, 1, 0, 8'd0, 8'd2, 16'hFFFF, 128'hBEEF);
    step(0, 1, 0, 0, 8'd2, 8'd0, 16'h0, '0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 8'd2, 8'd2, 16'hFFFF, rnd128());
    step(0, 1, 0, 0, 8'd2, 8'd0, 16'h0, '0);
    idle(3);
    // wbe=0 write is a no-op
    step(0, 0, 1, 0, 8'd0, 8'd4, 16'h0, rnd128());
    step(0, 1, 0, 0, 8'd4, 8'd0, 16'h0, '0);
    idle(2);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [7:0] r_a, w_a;
      r_a = $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      w_a = $urandom_range(0, 1) ? r_a : 8'($urandom_range(0, 255));
      step($urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
           r_a, w_a, $urandom_range(0, 1) ? 16'hFFFF : 16'($urandom), rnd128());
    end
    idle(3);
    // saturation and out-of-range addresses
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 8'd9, 8'd9, 16'hFFFF, rnd128());
    idle(2);
    chk("coll_sat", 1, 128'(cnt1), 128'd3);
    step(0, 1, 0, 0, 8'd250, 8'd0, 16'h0, '0);
    step(0, 0, 1, 0, 8'd0, 8'd250, 16'hFFFF, rnd128());
    step(0, 1, 0, 0, 8'd250, 8'd0, 16'h0, '0);
    idle(4);
    chk("drain", 0, 128'(sq.size()), 128'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
